// File: rtl/inst_mem_fetch.sv
// Writable instruction memory with a registered 1-cycle fetch, stall/flush handling and a post-reset clear sequence.
// Optional feature macro: IMEM_BOUNDS_CHECK_EN (out-of-range fetches return a NOP and raise inst_fault).
module inst_mem_fetch #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              stall,
  input  logic              flush,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              clear_done
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic              clear_done_q, clear_done_d;

  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] inst_out_q, inst_out_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_fault_q, inst_fault_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [IDX_W-1:0]  fetch_idx;
  logic              fetch_oob;
  logic              accept;

  assign fetch_idx = fetch_addr[IDX_W+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  logic [1:0] unused_addr_bits;
  assign unused_addr_bits = fetch_addr[1:0];
  assign fetch_oob        = |(fetch_addr >> (IDX_W + 2));
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[ADDR_W-1:IDX_W+2], fetch_addr[1:0]};
  assign fetch_oob        = 1'b0;
`endif

  // Clear/run control plus the single memory write port it arbitrates
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    clear_done_d = clear_done_q;
    fetch_ready  = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = prog_addr;
    mem_wdata    = prog_data;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d      = ST_RUN;
          clear_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        fetch_ready = !stall && !prog_mode;
        mem_we      = prog_mode && prog_we;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign accept = fetch_req && fetch_ready;

  // Output stage: flush beats stall beats accept
  always_comb begin
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    if (flush) begin
      inst_valid_d = 1'b0;
      inst_fault_d = 1'b0;
    end else if (stall) begin
      inst_valid_d = inst_valid_q;
    end else if (accept) begin
      inst_valid_d = 1'b1;
      inst_pc_d    = fetch_addr;
      inst_fault_d = fetch_oob;
      inst_out_d   = fetch_oob ? '0 : mem[fetch_idx];
    end else begin
      inst_valid_d = 1'b0;
      inst_fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
      clear_done_q <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      clear_done_q <= clear_done_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  // Storage array carries no reset; the clear sequence initialises it
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Randomized self-checking bench for inst_mem_fetch against a rule-level reference model.
module tb_inst_mem_fetch;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned IDX_W  = 8;

  logic              clk;
  logic              reset;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              stall;
  logic              flush;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_fault;
  logic              prog_mode;
  logic              prog_we;
  logic [IDX_W-1:0]  prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              clear_done;

  inst_mem_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .stall(stall), .flush(flush),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc), .inst_fault(inst_fault),
    .prog_mode(prog_mode), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .clear_done(clear_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic              m_valid, m_fault, m_done;
  logic [DATA_W-1:0] m_out;
  logic [ADDR_W-1:0] m_pc;
  int                m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_fault = 1'b0; m_done = 1'b0;
    m_out = '0; m_pc = '0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, inst_valid, m_valid);
    check({tag, "_out"},   inst_out,   m_out);
    check({tag, "_pc"},    inst_pc,    m_pc);
    check({tag, "_fault"}, inst_fault, m_fault);
    check({tag, "_done"},  clear_done, m_done);
  endtask

  // One clock: called at a negedge with inputs already driven
  task automatic tick();
    logic ready;
    logic oob;
    int   idx;
    #1;
    ready = m_done && !stall && !prog_mode;
    check("fetch_ready", fetch_ready, ready);
    idx = int'((fetch_addr >> 2) % DEPTH);
`ifdef IMEM_BOUNDS_CHECK_EN
    oob = (fetch_addr >> (IDX_W + 2)) != 0;
`else
    oob = 1'b0;
`endif
    if (flush) begin
      m_valid = 1'b0; m_fault = 1'b0;
    end else if (stall) begin
      m_valid = m_valid;
    end else if (ready && fetch_req) begin
      m_valid = 1'b1;
      m_pc    = fetch_addr;
      m_fault = oob;
      m_out   = oob ? '0 : m_mem[idx];
    end else begin
      m_valid = 1'b0; m_fault = 1'b0;
    end
    if (!m_done) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_done = 1'b1;
    end else if (prog_mode && prog_we) begin
      m_mem[prog_addr] = prog_data;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs("cyc");
  endtask

  // Asynchronous reset: outputs must drop without waiting for a clock edge
  task automatic apply_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs(tag);
    check({tag, "_ready"}, fetch_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0; flush = 1'b0;
    prog_mode = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
  endtask

  task automatic count_clear(input string tag);
    int n;
    n = 0;
    while (!clear_done && n < 300) begin
      tick();
      n++;
    end
    check(tag, 64'(n), 64'(DEPTH));
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    model_reset();
    @(negedge clk);
    apply_reset("rst0");

    // T1: clear length, no fetch accepted meanwhile, then top word reads zero
    fetch_req = 1'b1; fetch_addr = 32'h3FC;
    count_clear("t1_clear_cycles");
    tick();
    check("t1_valid", inst_valid, 1'b1);
    check("t1_out", inst_out, 32'h0);
    check("t1_pc", inst_pc, 32'h3FC);

    // T2: program two words, fetch them back
    fetch_req = 1'b0; prog_mode = 1'b1; prog_we = 1'b1;
    prog_addr = 8'd0; prog_data = 32'h2004_0000; tick();
    prog_addr = 8'd1; prog_data = 32'h2005_0020; tick();
    prog_mode = 1'b0; prog_we = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h0; tick();
    check("t2_out0", inst_out, 32'h2004_0000);
    check("t2_pc0", inst_pc, 32'h0);
    fetch_addr = 32'h4; tick();
    check("t2_out1", inst_out, 32'h2005_0020);
    check("t2_pc1", inst_pc, 32'h4);

    // T3: stall holds outputs even with a pending request
    tick();
    stall = 1'b1; fetch_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_out", inst_out, 32'h2005_0020);
      check("t3_hold_pc", inst_pc, 32'h4);
      check("t3_hold_valid", inst_valid, 1'b1);
    end
    stall = 1'b0; fetch_addr = 32'h0; tick();
    check("t3_resume_out", inst_out, 32'h2004_0000);

    // T4: flush wins over stall and fetch; nothing arrives late
    flush = 1'b1; stall = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h4; tick();
    check("t4_flush_valid", inst_valid, 1'b0);
    flush = 1'b0; stall = 1'b0; fetch_req = 1'b0; tick();
    check("t4_no_late", inst_valid, 1'b0);

    // T5: fetch beyond the array
    fetch_req = 1'b1; fetch_addr = 32'h400; tick();
`ifdef IMEM_BOUNDS_CHECK_EN
    check("t5_fault", inst_fault, 1'b1);
    check("t5_out", inst_out, 32'h0);
`else
    check("t5_fault", inst_fault, 1'b0);
    check("t5_out", inst_out, 32'h2004_0000);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      fetch_req  = ($urandom_range(0, 3) != 0);
      fetch_addr = ($urandom_range(0, 7) == 0) ? 32'($urandom) : (32'($urandom) & 32'h3FF);
      stall      = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 7) == 0);
      prog_mode  = ($urandom_range(0, 3) == 0);
      prog_we    = ($urandom_range(0, 1) == 1);
      prog_addr  = IDX_W'($urandom_range(0, DEPTH - 1));
      prog_data  = 32'($urandom);
      tick();
    end

    // T6: reset mid-RUN, then reset again at clear cycle 100
    idle_inputs();
    fetch_req = 1'b1; fetch_addr = 32'h4; tick();
    apply_reset("t6_rst_run");
    for (int i = 0; i < 100; i++) tick();
    apply_reset("t6_rst_clear");
    count_clear("t6_clear_cycles");
    fetch_addr = 32'h4; tick();
    check("t6_mem_cleared", inst_out, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
